// File: rtl/n_bit_logic_unit.sv
// Pipelined WIDTH-bit bitwise logic unit with zero/parity flags and valid/ready flow control.
// Optional LOGIC_UNIT_ACCUM_EN turns op 7 into ACCX (acc ^ A ^ B) with a running accumulator.
module n_bit_logic_unit #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       op,
  input  logic             enable,
  output logic [WIDTH-1:0] Y,
  output logic             zero,
  output logic             parity,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             z;
    logic             p;
  } beat_t;

  beat_t            data_q [STAGES];
  logic [STAGES-1:0] vld_q;
  beat_t            beat_d;
  logic [WIDTH-1:0] res_d;
  logic             adv;
  logic             accept;

  assign adv    = !vld_q[STAGES-1] || out_ready;
  assign accept = in_valid && adv;

`ifdef LOGIC_UNIT_ACCUM_EN
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;

  always_comb begin
    acc_d = acc_q;
    if (accept && enable && (op == 3'd7)) begin
      acc_d = res_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end
`endif

  always_comb begin
    res_d = '0;
    unique case (op)
      3'd0: res_d = A & B;
      3'd1: res_d = A | B;
      3'd2: res_d = A ^ B;
      3'd3: res_d = ~(A ^ B);
      3'd4: res_d = ~(A & B);
      3'd5: res_d = ~(A | B);
      3'd6: res_d = ~A;
`ifdef LOGIC_UNIT_ACCUM_EN
      3'd7: res_d = acc_q ^ A ^ B;
`else
      3'd7: res_d = A;
`endif
    endcase
    if (!enable) begin
      res_d = '0;
    end
  end

  always_comb begin
    beat_d   = '0;
    beat_d.y = res_d;
    beat_d.z = (res_d == '0);
    beat_d.p = ^res_d;
  end

  // Bubbles shift along with beats so latency is fixed at STAGES
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= '0;
      end
    end else if (adv) begin
      vld_q[0]  <= in_valid;
      data_q[0] <= beat_d;
      for (int i = 1; i < STAGES; i++) begin
        vld_q[i]  <= vld_q[i-1];
        data_q[i] <= data_q[i-1];
      end
    end
  end

  assign in_ready  = adv;
  assign out_valid = vld_q[STAGES-1];
  assign Y         = data_q[STAGES-1].y;
  assign zero      = data_q[STAGES-1].z;
  assign parity    = data_q[STAGES-1].p;

endmodule

// File: tb/tb_n_bit_logic_unit.sv
// Directed self-checking bench for n_bit_logic_unit (WIDTH=8, STAGES=2).
module tb_n_bit_logic_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] A;
  logic [7:0] B;
  logic [2:0] op;
  logic       enable;
  logic [7:0] Y;
  logic       zero;
  logic       parity;
  logic       out_valid;
  logic       out_ready;

  int checks = 0;
  int fails  = 0;

  n_bit_logic_unit #(.WIDTH(8), .STAGES(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .op       (op),
    .enable   (enable),
    .Y        (Y),
    .zero     (zero),
    .parity   (parity),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] a,
                       input logic [7:0] b, input logic [2:0] o,
                       input logic en);
    in_valid = v;
    A        = a;
    B        = b;
    op       = o;
    enable   = en;
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
  endtask

  // One beat, then check exact 2-cycle latency and the result
  task automatic one_beat(input string tag, input logic [7:0] a,
                          input logic [7:0] b, input logic [2:0] o,
                          input logic en, input logic [7:0] ey,
                          input logic ez, input logic ep);
    drive(1'b1, a, b, o, en);
    @(negedge clk);
    idle();
    chk({tag, "_lat1"}, out_valid, 0);
    @(negedge clk);
    chk({tag, "_vld"}, out_valid, 1);
    chk({tag, "_y"}, Y, ey);
    chk({tag, "_z"}, zero, ez);
    chk({tag, "_p"}, parity, ep);
    @(negedge clk);
    chk({tag, "_gone"}, out_valid, 0);
  endtask

  logic [7:0] exp_s [7];

  initial begin
    exp_s = '{8'h05, 8'hAF, 8'hAA, 8'h55, 8'hFA, 8'h50, 8'h5A};
    reset     = 1'b1;
    out_ready = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    chk("rst_vld", out_valid, 0);
    chk("rst_y", Y, 0);
    chk("rst_z", zero, 0);
    chk("rst_p", parity, 0);
    reset = 1'b0;
    chk("rst_rdy", in_ready, 1);

    one_beat("xor", 8'hF0, 8'h3C, 3'd2, 1'b1, 8'hCC, 1'b0, 1'b0);
    one_beat("en0", 8'hF0, 8'h3C, 3'd2, 1'b0, 8'h00, 1'b1, 1'b0);

    for (int c = 0; c < 9; c++) begin
      if (c < 7) drive(1'b1, 8'hA5, 8'h0F, 3'(c), 1'b1);
      else idle();
      @(negedge clk);
      if (c >= 1 && c <= 7) begin
        chk($sformatf("strm_vld%0d", c - 1), out_valid, 1);
        chk($sformatf("strm_y%0d", c - 1), Y, exp_s[c-1]);
      end
    end
    chk("strm_end", out_valid, 0);

    out_ready = 1'b0;
    drive(1'b1, 8'h11, 8'h22, 3'd1, 1'b1);
    @(negedge clk);
    drive(1'b1, 8'hFF, 8'h0F, 3'd0, 1'b1);
    @(negedge clk);
    idle();
    chk("stl_rdy", in_ready, 0);
    chk("stl_vld", out_valid, 1);
    chk("stl_y", Y, 8'h33);
    repeat (3) @(negedge clk);
    chk("stl_rdy2", in_ready, 0);
    chk("stl_hold", Y, 8'h33);
    chk("stl_hvld", out_valid, 1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("rel_vld", out_valid, 1);
    chk("rel_y", Y, 8'h0F);
    chk("rel_p", parity, 0);
    @(negedge clk);
    chk("rel_end", out_valid, 0);

    drive(1'b1, 8'hFF, 8'h77, 3'd0, 1'b1);
    @(negedge clk);
    drive(1'b1, 8'h80, 8'h01, 3'd1, 1'b1);
    @(negedge clk);
    idle();
    chk("mid_vld", out_valid, 1);
    chk("mid_y", Y, 8'h77);
    reset = 1'b1;
    @(negedge clk);
    chk("mrst_vld", out_valid, 0);
    reset = 1'b0;
    chk("mrst_rdy", in_ready, 1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("mrst_drop%0d", c), out_valid, 0);
    end

`ifdef LOGIC_UNIT_ACCUM_EN
    drive(1'b1, 8'h01, 8'h02, 3'd7, 1'b1);
    @(negedge clk);
    drive(1'b1, 8'h04, 8'h00, 3'd7, 1'b1);
    @(negedge clk);
    idle();
    chk("accx0_vld", out_valid, 1);
    chk("accx0_y", Y, 8'h03);
    @(negedge clk);
    chk("accx1_vld", out_valid, 1);
    chk("accx1_y", Y, 8'h07);
    chk("accx1_p", parity, 1);
`else
    one_beat("pass", 8'h01, 8'hFF, 3'd7, 1'b1, 8'h01, 1'b0, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
